output_collect_buffer: RTL and testbench

//  Per-lane result collector at the south edge of the systolic array; the receive-side counterpart of the per-lane input queues.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/collect_ring.sv | 66 ++++++
 rtl/output_collect_buffer.sv | 118 +++++++++++
 tb/tb_output_collect_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge buffers: phase bus codes, word width, collector FSM states.
package systolic_pkg;

  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_LOAD   = 2'b01;
  localparam logic [1:0] PH_STREAM = 2'b10;
  localparam logic [1:0] PH_DRAIN  = 2'b11;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    C_IDLE    = 2'b00,
    C_SKEW    = 2'b01,
    C_CAPTURE = 2'b10,
    C_DRAIN   = 2'b11
  } collect_state_t;

endpackage

// File: rtl/collect_ring.sv
// Circular word store with head/tail pointers and occupancy count; depth need not be a power of two.
module collect_ring
  import systolic_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
  endfunction

  // Occupancy flags and head word, decoded from registered state.
  always_comb begin
    full    = (count == DEPTH_CNT);
    empty   = (count == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    rd_data = mem[head];
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointer and count update; push and pop may both be handled in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= next_idx(tail);
      if (pop_ok)  head <= next_idx(head);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_collect_buffer.sv
// Per-column result collector: drops the lane's skew cycles, captures results while streaming,
// and plays them out over valid/ready during drain.
module output_collect_buffer
  import systolic_pkg::*;
#(
  parameter int unsigned ARR_SIZE    = 4,
  parameter int unsigned LANE_INDEX  = 0,
  parameter int unsigned SKEW        = LANE_INDEX,
  parameter int unsigned QUEUE_DEPTH = ARR_SIZE * 2,
  parameter int unsigned ADDR_WIDTH  = $clog2(QUEUE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            state,
  input  logic [DATA_W-1:0]     array_output,
  input  logic                  array_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  drain_done
);

  localparam int unsigned     SKW_W     = (SKEW > 1) ? $clog2(SKEW) : 1;
  localparam logic [SKW_W-1:0] SKEW_LOAD = SKW_W'((SKEW > 0) ? SKEW - 1 : 0);

  collect_state_t    fsm_q;
  collect_state_t    fsm_d;
  logic [SKW_W-1:0]  skew_q;
  logic [SKW_W-1:0]  skew_d;
  logic              flush_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic [DATA_W-1:0] rd_data;

  collect_ring #(
    .DEPTH  (QUEUE_DEPTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_c),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (array_output),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // FSM and skew counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= C_IDLE;
      skew_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      skew_q <= skew_d;
    end
  end

  // Next state from the sampled phase; the datapath acts on the mode selected this cycle,
  // so SKEW=0 captures on the first stream cycle and a drain starts with the phase change.
  always_comb begin
    fsm_d   = C_IDLE;
    skew_d  = skew_q;
    flush_c = 1'b0;
    case (state)
      PH_LOAD: begin
        flush_c = 1'b1;
        fsm_d   = C_IDLE;
      end
      PH_STREAM: begin
        if (fsm_q == C_SKEW) begin
          if (skew_q == '0) begin
            fsm_d = C_CAPTURE;
          end else begin
            skew_d = skew_q - SKW_W'(1);
            fsm_d  = C_SKEW;
          end
        end else if (fsm_q == C_CAPTURE) begin
          fsm_d = C_CAPTURE;
        end else if (SKEW > 0) begin
          skew_d = SKEW_LOAD;
          fsm_d  = C_SKEW;
        end else begin
          fsm_d = C_CAPTURE;
        end
      end
      PH_DRAIN: fsm_d = C_DRAIN;
      default:  fsm_d = C_IDLE;
    endcase

    push_c    = (fsm_d == C_CAPTURE) && array_valid && !full;
    drop_c    = (fsm_d == C_CAPTURE) && array_valid && full;
    out_valid = (fsm_d == C_DRAIN) && !empty;
    pop_c     = out_valid && out_ready;
    out_data  = out_valid ? rd_data : '0;
  end

  // Sticky overflow flag and end-of-drain pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      if (flush_c)     overflow <= 1'b0;
      else if (drop_c) overflow <= 1'b1;
      drain_done <= pop_c && (count == (ADDR_WIDTH + 1)'(1));
    end
  end

endmodule

// File: tb/tb_output_collect_buffer.sv
// Directed bench for output_collect_buffer: a skew-2 lane (dut_a) and a skew-0 lane (dut_b) on shared inputs.
module tb_output_collect_buffer;
  import systolic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [15:0] array_output;
  logic        array_valid;
  logic        out_ready;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic [3:0]  a_count, b_count;
  logic        a_full, b_full, a_empty, b_empty, a_ovf, b_ovf, a_done, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_collect_buffer #(.ARR_SIZE(4), .LANE_INDEX(2)) dut_a (
    .clk(clk), .rst(rst), .state(state), .array_output(array_output), .array_valid(array_valid),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow(a_ovf), .drain_done(a_done)
  );

  output_collect_buffer #(.ARR_SIZE(4), .LANE_INDEX(0)) dut_b (
    .clk(clk), .rst(rst), .state(state), .array_output(array_output), .array_valid(array_valid),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow(b_ovf), .drain_done(b_done)
  );

  typedef struct {
    logic        chk;
    logic        sel;
    logic [1:0]  ph;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_data;
    int          e_count;
    logic        e_full;
    logic        e_ovf;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs away from the active edge, then settle before checking.
  task automatic drive(input logic r, input logic [1:0] ph, input logic v, input logic [15:0] d,
                       input logic rdy);
    @(negedge clk);
    rst = r; state = ph; array_valid = v; array_output = d; out_ready = rdy;
    #1;
  endtask

  task automatic add(input logic c, input logic s, input logic [1:0] ph, input logic v,
                     input logic [15:0] d, input logic rdy, input logic ev, input logic [15:0] ed,
                     input int ec, input logic ef, input logic eo, input logic edn);
    vec_t t;
    t.chk = c; t.sel = s; t.ph = ph; t.v = v; t.d = d; t.rdy = rdy;
    t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_full = ef; t.e_ovf = eo; t.e_done = edn;
    vecs.push_back(t);
  endtask

  initial begin
    logic        o_valid, o_full, o_ovf, o_done;
    logic [15:0] o_data;
    logic [3:0]  o_count;

    rst = 1'b1; state = PH_IDLE; array_valid = 1'b0; array_output = '0; out_ready = 1'b0;

    // Test 1: skew-2 lane drops words 1,2, keeps 3..6 (dut_a)
    add(0, 0, PH_LOAD, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd1, 0, 0, 16'h0, 0, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd2, 0, 0, 16'h0, 0, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd3, 0, 0, 16'h0, 0, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd4, 0, 0, 16'h0, 1, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd5, 0, 0, 16'h0, 2, 0, 0, 0);
    add(1, 0, PH_STREAM, 1, 16'd6, 0, 0, 16'h0, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, PH_DRAIN, 0, 16'h0, 1, 1, 16'(3 + i), 4 - i, 0, 0, 0);
    add(1, 0, PH_DRAIN, 0, 16'h0, 1, 0, 16'h0, 0, 0, 0, 1);
    add(1, 0, PH_DRAIN, 0, 16'h0, 1, 0, 16'h0, 0, 0, 0, 0);

    // Test 2: skew-0 lane, 10 words into depth 8 (dut_b)
    add(0, 1, PH_LOAD, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(1, 1, PH_STREAM, 1, 16'(16'hA0 + i), 0, 0, 16'h0, (i > 8) ? 8 : i, i >= 8, i == 9, 0);
    for (int i = 0; i < 8; i++)
      add(1, 1, PH_DRAIN, 0, 16'h0, 1, 1, 16'(16'hA0 + i), 8 - i, i == 0, 1, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 1, 0, 16'h0, 0, 0, 1, 1);

    // Test 3: drain with out_ready toggling (dut_b)
    add(0, 1, PH_LOAD, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 1, PH_STREAM, 1, 16'(16'hB0 + i), 0, 0, 16'h0, i, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 1, 1, 16'hB0, 3, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 0, 1, 16'hB1, 2, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 1, 1, 16'hB1, 2, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 0, 1, 16'hB2, 1, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 1, 1, 16'hB2, 1, 0, 0, 0);
    add(1, 1, PH_DRAIN, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_valid", a_valid, 0);  chk("rst_a_data", a_data, 0);
    chk("rst_a_empty", a_empty, 1);  chk("rst_a_full", a_full, 0);
    chk("rst_a_count", a_count, 0);  chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_valid", b_valid, 0);  chk("rst_b_empty", b_empty, 1);
    chk("rst_b_done", b_done, 0);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].ph, vecs[i].v, vecs[i].d, vecs[i].rdy);
      if (vecs[i].chk) begin
        o_valid = vecs[i].sel ? b_valid : a_valid;
        o_data  = vecs[i].sel ? b_data  : a_data;
        o_count = vecs[i].sel ? b_count : a_count;
        o_full  = vecs[i].sel ? b_full  : a_full;
        o_ovf   = vecs[i].sel ? b_ovf   : a_ovf;
        o_done  = vecs[i].sel ? b_done  : a_done;
        chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].e_valid);
        chk($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
        chk($sformatf("vec%0d_count", i), o_count, vecs[i].e_count);
        chk($sformatf("vec%0d_full", i), o_full, vecs[i].e_full);
        chk($sformatf("vec%0d_ovf", i), o_ovf, vecs[i].e_ovf);
        chk($sformatf("vec%0d_done", i), o_done, vecs[i].e_done);
      end
    end

    // Test 4: pause a drain with idle phase, then resume (dut_b)
    drive(0, PH_LOAD, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, PH_STREAM, 1, 16'(16'hC0 + i), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, PH_DRAIN, 0, 0, 1);
      chk("t4_drain_data", b_data, 16'hC0 + i);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, PH_IDLE, 0, 0, 1);
      chk("t4_pause_valid", b_valid, 0);
      chk("t4_pause_count", b_count, 2);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, PH_DRAIN, 0, 0, 1);
      chk("t4_resume_valid", b_valid, 1);
      chk("t4_resume_data", b_data, 16'hC3 + i);
    end
    drive(0, PH_DRAIN, 0, 0, 0);
    chk("t4_end_empty", b_empty, 1);

    // Test 5: pointer wrap (dut_b)
    drive(0, PH_LOAD, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, PH_STREAM, 1, 16'(16'hD0 + i), 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, PH_DRAIN, 0, 0, 1);
      chk("t5_first_data", b_data, 16'hD0 + i);
    end
    for (int i = 0; i < 5; i++) drive(0, PH_STREAM, 1, 16'(16'hE0 + i), 0);
    drive(0, PH_DRAIN, 0, 0, 0);
    chk("t5_wrap_count", b_count, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, PH_DRAIN, 0, 0, 1);
      chk("t5_wrap_data", b_data, 16'hE0 + i);
    end
    drive(0, PH_DRAIN, 0, 0, 1);
    chk("t5_end_empty", b_empty, 1);
    chk("t5_end_valid", b_valid, 0);

    // Test 6: reset in the middle of capture (dut_b)
    drive(0, PH_LOAD, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, PH_STREAM, 1, 16'(16'hF0 + i), 0);
    drive(0, PH_STREAM, 0, 0, 0);
    chk("t6_pre_count", b_count, 4);
    drive(1, PH_STREAM, 1, 16'hFF, 0);
    drive(0, PH_STREAM, 1, 16'h5A, 0);
    chk("t6_count", b_count, 0);
    chk("t6_empty", b_empty, 1);
    chk("t6_valid", b_valid, 0);
    chk("t6_ovf", b_ovf, 0);
    drive(0, PH_DRAIN, 0, 0, 1);
    chk("t6_post_data", b_data, 16'h5A);
    chk("t6_post_count", b_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
